// File: rtl/rp_level_decoder.sv
// rtl/rp_level_decoder.sv - iterative NTRU Prime radix-list decoder, deepest level up to level 0
module rp_level_decoder #(
    parameter int OUT_DEPTH   = 11,
    parameter int OUT_D_SIZE  = 8,
    parameter int RP_DEPTH    = 11,
    parameter int RP_D_SIZE   = 13,
    parameter int RP_INV_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   done,
    output logic [OUT_DEPTH-1:0]   rp_rd_addr,
    input  logic [OUT_D_SIZE-1:0]  rp_rd_data,
    output logic [RP_DEPTH-1:0]    cd_wr_addr,
    output logic [RP_D_SIZE-1:0]   cd_wr_data,
    output logic                   cd_wr_en,
    output logic [4:0]             state_l,
    output logic [4:0]             state_e,
    output logic [4:0]             state_s,
    input  logic [4:0]             state_max,
    input  logic [RP_DEPTH-2:0]    param_r_max,
    input  logic [RP_DEPTH-1:0]    param_ro_max,
    input  logic                   param_small_r2,
    input  logic                   param_small_r3,
    input  logic [RP_DEPTH-1:0]    param_state_ct,
    input  logic [RP_DEPTH-2:0]    param_ri_offset,
    input  logic [RP_DEPTH-2:0]    param_ri_len,
    input  logic [OUT_DEPTH-1:0]   param_outoffset,
    input  logic [1:0]             param_outs1,
    input  logic [1:0]             param_outsl,
    input  logic [RP_D_SIZE-1:0]   param_m0,
    input  logic [RP_INV_SIZE-1:0] param_m0inv,
    input  logic [RP_DEPTH-2:0]    param_ro_offset
);

    localparam int BW      = 2 * OUT_D_SIZE;
    localparam int RW      = RP_D_SIZE + BW;
    localparam int PW      = RW + RP_INV_SIZE;
    localparam int DEPTH_N = 1 << RP_DEPTH;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_MUL, S_DIV, S_WRQ, S_PASS0, S_PASS1, S_FIN
    } state_t;

    state_t state, state_nx;

    logic [4:0]            lvl;
    logic [RP_DEPTH-2:0]   j;
    logic                  phase;
    logic [OUT_D_SIZE-1:0] byte0;
    logic [RW-1:0]         r_val, q_val;
    logic                  wr_bank;
    logic                  start_q;

    logic [RP_D_SIZE-1:0]  bank0 [0:DEPTH_N-1];
    logic [RP_D_SIZE-1:0]  bank1 [0:DEPTH_N-1];
    logic [RP_D_SIZE-1:0]  buf_q;

    logic                  accept, to_cd, lvl_end;
    logic [OUT_DEPTH-1:0]  j_bytes, byte_base;
    logic [1:0]            n_bytes;
    logic [BW-1:0]         bottom;
    logic [RW-1:0]         r2_ext, r_pair, r_fetch;
    logic [PW-1:0]         prod;
    logic [RW-1:0]         q_est, m0_ext, rem0, rem1, rem2, q1, q2;
    logic [RP_DEPTH-1:0]   pass_idx, pair_idx, rd_idx;
    logic                  wr_go;
    logic [RP_DEPTH-1:0]   wr_k, wr_addr;
    logic [RP_D_SIZE-1:0]  wr_val;
    logic                  unused_ok;

    assign state_l = lvl;
    assign state_e = lvl;
    assign state_s = lvl;

    // Edge-qualified so a start held across completion cannot relaunch a decode.
    assign accept = (state == S_IDLE) && start && !start_q;
    assign to_cd  = (lvl == 5'd0);

    always_comb begin
        case (param_outs1)
            2'd1:    j_bytes = OUT_DEPTH'(j);
            2'd2:    j_bytes = OUT_DEPTH'({j, 1'b0});
            default: j_bytes = '0;
        endcase
    end

    assign byte_base = param_outoffset + j_bytes;
    assign n_bytes   = param_small_r3 ? param_outsl : param_outs1;

    always_comb begin
        rp_rd_addr = '0;
        if (state == S_FETCH0) begin
            rp_rd_addr = byte_base;
        end else if (state == S_FETCH1) begin
            rp_rd_addr = byte_base + OUT_DEPTH'(1);
        end
    end

    // The second byte is consumed straight off the RAM port in FETCH2.
    always_comb begin
        r2_ext = RW'(buf_q);
        case (n_bytes)
            2'd0: begin
                bottom = '0;
                r_pair = r2_ext;
            end
            2'd1: begin
                bottom = BW'(byte0);
                r_pair = (r2_ext << OUT_D_SIZE) | RW'(bottom);
            end
            default: begin
                bottom = {rp_rd_data, byte0};
                r_pair = (r2_ext << BW) | RW'(bottom);
            end
        endcase
        r_fetch = param_small_r3 ? RW'(bottom) : r_pair;
    end

    // Reciprocal estimate undershoots the true quotient by at most two.
    assign prod   = PW'(r_val) * PW'(param_m0inv);
    assign q_est  = prod[PW-1:RP_INV_SIZE];
    assign m0_ext = RW'(param_m0);
    assign rem0   = r_val - q_val * m0_ext;

    always_comb begin
        rem1 = rem0;
        q1   = q_val;
        if (rem0 >= m0_ext) begin
            rem1 = rem0 - m0_ext;
            q1   = q_val + RW'(1);
        end
        rem2 = rem1;
        q2   = q1;
        if (rem1 >= m0_ext) begin
            rem2 = rem1 - m0_ext;
            q2   = q1 + RW'(1);
        end
    end

    assign pass_idx = RP_DEPTH'(param_ri_offset) + RP_DEPTH'(param_ri_len);
    assign pair_idx = RP_DEPTH'(param_ri_offset) + RP_DEPTH'(j);
    assign rd_idx   = (state == S_PASS0 || state == S_PASS1) ? pass_idx : pair_idx;

    always_comb begin
        state_nx = state;
        lvl_end  = 1'b0;
        wr_go    = 1'b0;
        wr_k     = '0;
        wr_val   = '0;
        case (state)
            S_IDLE:   if (accept) state_nx = S_FETCH0;
            S_FETCH0: state_nx = S_FETCH1;
            S_FETCH1: state_nx = S_FETCH2;
            S_FETCH2: state_nx = S_MUL;
            S_MUL:    state_nx = S_DIV;
            S_DIV: begin
                wr_go  = 1'b1;
                wr_val = rem2[RP_D_SIZE-1:0];
                if (param_small_r3) begin
                    lvl_end = 1'b1;
                end else begin
                    wr_k = {j, phase};
                    if (phase) begin
                        state_nx = S_FETCH0;
                    end else if (j == param_r_max) begin
                        state_nx = S_WRQ;
                    end else begin
                        state_nx = S_MUL;
                    end
                end
            end
            S_WRQ: begin
                wr_go  = 1'b1;
                wr_k   = {j, 1'b1};
                wr_val = q_val[RP_D_SIZE-1:0];
                if (param_small_r2) begin
                    state_nx = S_PASS0;
                end else begin
                    lvl_end = 1'b1;
                end
            end
            S_PASS0:  state_nx = S_PASS1;
            S_PASS1: begin
                wr_go   = 1'b1;
                wr_k    = param_ro_max;
                wr_val  = buf_q;
                lvl_end = 1'b1;
            end
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (lvl_end) begin
            state_nx = to_cd ? S_FIN : S_FETCH0;
        end
    end

    assign wr_addr = param_small_r3 ? '0 : RP_DEPTH'(param_ro_offset) + wr_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ping-pong work buffers: the level writes wr_bank and reads the other one.
    always_ff @(posedge clk) begin
        if (wr_go && !to_cd) begin
            if (wr_bank) begin
                bank1[wr_addr] <= wr_val;
            end else begin
                bank0[wr_addr] <= wr_val;
            end
        end
        buf_q <= wr_bank ? bank0[rd_idx] : bank1[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            done       <= 1'b0;
            lvl        <= '0;
            j          <= '0;
            phase      <= 1'b0;
            byte0      <= '0;
            r_val      <= '0;
            q_val      <= '0;
            wr_bank    <= 1'b0;
            cd_wr_en   <= 1'b0;
            cd_wr_addr <= '0;
            cd_wr_data <= '0;
        end else begin
            start_q  <= start;
            cd_wr_en <= wr_go && to_cd;
            if (wr_go && to_cd) begin
                cd_wr_addr <= wr_k;
                cd_wr_data <= wr_val;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        done  <= 1'b0;
                        lvl   <= state_max;
                        j     <= '0;
                        phase <= 1'b0;
                    end
                end
                S_FETCH1: byte0 <= rp_rd_data;
                S_FETCH2: r_val <= r_fetch;
                S_MUL:    q_val <= q_est;
                S_DIV: begin
                    q_val <= q2;
                    if (!param_small_r3) begin
                        if (phase) begin
                            phase <= 1'b0;
                            j     <= j + (RP_DEPTH-1)'(1);
                        end else if (j != param_r_max) begin
                            r_val <= q2;
                            phase <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    lvl  <= '0;
                end
                default: ;
            endcase
            if (lvl_end && !to_cd) begin
                lvl     <= lvl - 5'd1;
                j       <= '0;
                phase   <= 1'b0;
                wr_bank <= ~wr_bank;
            end
        end
    end

    assign unused_ok = ^{param_state_ct, prod[RP_INV_SIZE-1:0], rem2[RW-1:RP_D_SIZE]};

endmodule

// File: tb/tb_rp_level_decoder.sv
// tb/tb_rp_level_decoder.sv - scoreboard bench for rp_level_decoder
module tb_rp_level_decoder;

    localparam int OUT_DEPTH   = 11;
    localparam int OUT_D_SIZE  = 8;
    localparam int RP_DEPTH    = 11;
    localparam int RP_D_SIZE   = 13;
    localparam int RP_INV_SIZE = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   start = 1'b0;
    logic                   done;
    logic [OUT_DEPTH-1:0]   rp_rd_addr;
    logic [OUT_D_SIZE-1:0]  rp_rd_data;
    logic [RP_DEPTH-1:0]    cd_wr_addr;
    logic [RP_D_SIZE-1:0]   cd_wr_data;
    logic                   cd_wr_en;
    logic [4:0]             state_l, state_e, state_s;
    logic [4:0]             state_max;
    logic [RP_DEPTH-2:0]    param_r_max, param_ri_offset, param_ri_len, param_ro_offset;
    logic [RP_DEPTH-1:0]    param_ro_max, param_state_ct;
    logic                   param_small_r2, param_small_r3;
    logic [OUT_DEPTH-1:0]   param_outoffset;
    logic [1:0]             param_outs1, param_outsl;
    logic [RP_D_SIZE-1:0]   param_m0;
    logic [RP_INV_SIZE-1:0] param_m0inv;

    logic [OUT_D_SIZE-1:0]  mem [0:(1<<OUT_DEPTH)-1];

    logic [RP_DEPTH-2:0]    t_r_max [4];
    logic [RP_DEPTH-2:0]    t_ri_len [4];
    logic [RP_DEPTH-1:0]    t_ro_max [4];
    logic [RP_DEPTH-1:0]    t_state_ct [4];
    logic                   t_r2 [4];
    logic                   t_r3 [4];
    logic [OUT_DEPTH-1:0]   t_outoffset [4];
    logic [1:0]             t_outs1 [4];
    logic [1:0]             t_outsl [4];
    logic [RP_D_SIZE-1:0]   t_m0 [4];
    logic [RP_INV_SIZE-1:0] t_m0inv [4];

    logic [RP_DEPTH+RP_D_SIZE-1:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    rp_level_decoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .rp_rd_addr(rp_rd_addr), .rp_rd_data(rp_rd_data),
        .cd_wr_addr(cd_wr_addr), .cd_wr_data(cd_wr_data), .cd_wr_en(cd_wr_en),
        .state_l(state_l), .state_e(state_e), .state_s(state_s), .state_max(state_max),
        .param_r_max(param_r_max), .param_ro_max(param_ro_max),
        .param_small_r2(param_small_r2), .param_small_r3(param_small_r3),
        .param_state_ct(param_state_ct), .param_ri_offset(param_ri_offset),
        .param_ri_len(param_ri_len), .param_outoffset(param_outoffset),
        .param_outs1(param_outs1), .param_outsl(param_outsl),
        .param_m0(param_m0), .param_m0inv(param_m0inv), .param_ro_offset(param_ro_offset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rp_rd_data <= mem[rp_rd_addr];

    assign param_outoffset = t_outoffset[state_l[1:0]];
    assign param_outs1     = t_outs1[state_l[1:0]];
    assign param_outsl     = t_outsl[state_l[1:0]];
    assign param_state_ct  = t_state_ct[state_l[1:0]];
    assign param_ri_offset = '0;
    assign param_ri_len    = t_ri_len[state_l[1:0]];
    assign param_m0        = t_m0[state_e[1:0]];
    assign param_m0inv     = t_m0inv[state_e[1:0]];
    assign param_small_r2  = t_r2[state_e[1:0]];
    assign param_small_r3  = t_r3[state_e[1:0]];
    assign param_r_max     = t_r_max[state_e[1:0]];
    assign param_ro_offset = '0;
    assign param_ro_max    = t_ro_max[state_s[1:0]];

    always @(negedge clk) begin
        if (rst_n && cd_wr_en) begin
            logic [RP_DEPTH+RP_D_SIZE-1:0] want;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL cd_unexpected got addr=%0d data=%0d required no write", cd_wr_addr, cd_wr_data);
            end else begin
                want = exp_q.pop_front();
                if ({cd_wr_addr, cd_wr_data} !== want) begin
                    failures++;
                    $display("FAIL cd_write got addr=%0d data=%0d required addr=%0d data=%0d",
                             cd_wr_addr, cd_wr_data, want[RP_DEPTH+RP_D_SIZE-1:RP_D_SIZE], want[RP_D_SIZE-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic expect_cd(input int addr, input int data);
        exp_q.push_back({RP_DEPTH'(addr), RP_D_SIZE'(data)});
    endtask

    task automatic clear_table();
        for (int lv = 0; lv < 4; lv++) begin
            t_r_max[lv] = '0; t_ri_len[lv] = '0; t_ro_max[lv] = '0; t_state_ct[lv] = '0;
            t_r2[lv] = 1'b0; t_r3[lv] = 1'b0; t_outoffset[lv] = '0; t_outs1[lv] = '0;
            t_outsl[lv] = '0; t_m0[lv] = '0; t_m0inv[lv] = '0;
        end
        for (int a = 0; a < 8; a++) mem[a] = '0;
    endtask

    task automatic set_level(input int lv, input bit r3, input int outsl, input int outoff,
                             input int outs1, input int m0, input int r_max, input int ro_max,
                             input bit r2, input int ri_len);
        t_r3[lv]        = r3;
        t_outsl[lv]     = 2'(outsl);
        t_outoffset[lv] = OUT_DEPTH'(outoff);
        t_outs1[lv]     = 2'(outs1);
        t_m0[lv]        = RP_D_SIZE'(m0);
        t_m0inv[lv]     = RP_INV_SIZE'((64'd1 << RP_INV_SIZE) / 64'(m0));
        t_r_max[lv]     = (RP_DEPTH-1)'(r_max);
        t_ro_max[lv]    = RP_DEPTH'(ro_max);
        t_r2[lv]        = r2;
        t_ri_len[lv]    = (RP_DEPTH-1)'(ri_len);
        t_state_ct[lv]  = RP_DEPTH'(r3 ? outsl : outs1 * (r_max + 1));
    endtask

    task automatic table_basic();
        clear_table();
        state_max = 5'd1;
        set_level(1, 1'b1, 1, 0, 0, 9, 0, 0, 1'b0, 0);
        set_level(0, 1'b0, 0, 0, 0, 3, 0, 1, 1'b0, 0);
    endtask

    task automatic table_bottom();
        clear_table();
        state_max = 5'd1;
        set_level(1, 1'b1, 2, 2, 0, 322, 0, 0, 1'b0, 0);
        set_level(0, 1'b0, 0, 0, 2, 4591, 0, 1, 1'b0, 0);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h05; mem[3] = 8'h00;
    endtask

    task automatic run(input string name, input bit hold6, input bit poke_busy);
        @(posedge clk); #1 start = 1'b1;
        if (hold6) repeat (6) @(posedge clk);
        else @(posedge clk);
        #1 start = 1'b0;
        if (poke_busy) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk({name, "_done"}, longint'(done), 1);
        repeat (10) @(posedge clk);
        #1;
        chk({name, "_done_held"}, longint'(done), 1);
        chk({name, "_state_l"}, longint'(state_l), 0);
        chk({name, "_state_e"}, longint'(state_e), 0);
        chk({name, "_state_s"}, longint'(state_s), 0);
        chk({name, "_pending"}, longint'(exp_q.size()), 0);
    endtask

    initial begin
        clear_table();
        state_max = 5'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_done", longint'(done), 0);
        chk("rst_cd_wr_en", longint'(cd_wr_en), 0);
        chk("rst_cd_wr_addr", longint'(cd_wr_addr), 0);
        chk("rst_cd_wr_data", longint'(cd_wr_data), 0);
        chk("rst_rp_rd_addr", longint'(rp_rd_addr), 0);
        chk("rst_state_l", longint'(state_l), 0);
        chk("rst_state_e", longint'(state_e), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        table_basic();
        mem[0] = 8'd7;
        expect_cd(0, 1); expect_cd(1, 2);
        run("basic", 1'b0, 1'b0);

        table_bottom();
        expect_cd(0, 1788); expect_cd(1, 72);
        run("bottom", 1'b0, 1'b0);

        clear_table();
        state_max = 5'd2;
        set_level(2, 1'b1, 1, 0, 0, 27, 0, 0, 1'b0, 0);
        set_level(1, 1'b0, 0, 0, 0, 9, 0, 1, 1'b0, 0);
        set_level(0, 1'b0, 0, 0, 0, 3, 0, 2, 1'b1, 1);
        mem[0] = 8'd26;
        expect_cd(0, 2); expect_cd(1, 2); expect_cd(2, 2);
        run("odd", 1'b0, 1'b0);

        table_basic();
        mem[0] = 8'd200;
        expect_cd(0, 2); expect_cd(1, 0);
        run("oor", 1'b0, 1'b0);

        table_basic();
        mem[0] = 8'd7;
        expect_cd(0, 1); expect_cd(1, 2);
        run("held", 1'b1, 1'b1);

        table_bottom();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_done", longint'(done), 0);
        chk("abort_cd_wr_en", longint'(cd_wr_en), 0);
        chk("abort_state_l", longint'(state_l), 0);
        chk("abort_rp_rd_addr", longint'(rp_rd_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_cd(0, 1788); expect_cd(1, 72);
        run("after_reset", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rp_level_decoder.md
Name: rp_level_decoder

Overview:
- Iterative hardware form of the NTRU Prime radix-list Decode(S, M).
- Reads the encoded byte stream from an external synchronous byte RAM and fetches per-level constants from an external combinational parameter table.
- Rebuilds the coefficient list level by level, from the deepest (single-element) level up to level 0.
- Writes the level-0 result to an external coefficient RAM and raises done.

Parameters:
- OUT_DEPTH, 11: byte-stream address width.
- OUT_D_SIZE, 8: byte width.
- RP_DEPTH, 11: coefficient index width.
- RP_D_SIZE, 13: coefficient width.
- RP_INV_SIZE, 32: reciprocal-constant width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; accepted only when idle.
- done  out  1  high from completion until the next accepted start.
- rp_rd_addr  out  OUT_DEPTH  byte address.
- rp_rd_data  in  OUT_D_SIZE  byte returned one cycle after its address.
- cd_wr_addr  out  RP_DEPTH  output coefficient index.
- cd_wr_data  out  RP_D_SIZE  output coefficient.
- cd_wr_en  out  1  write strobe.
- state_l, state_e, state_s  out  5  level index presented to the table (load / execute / store stage).
- state_max  in  5  deepest level index.
- param_r_max  in  RP_DEPTH-1  last pair index at the level.
- param_ro_max  in  RP_DEPTH  last output index at the level.
- param_small_r2  in  1  level length is odd; last entry is a pass-through.
- param_small_r3  in  1  base level: value is read directly from bytes.
- param_state_ct  in  RP_DEPTH  total bottom bytes consumed at the level.
- param_ri_offset, param_ri_len  in  RP_DEPTH-1  first index and (count-1) of the R2 inputs.
- param_outoffset  in  OUT_DEPTH  first byte address for the level.
- param_outs1  in  2  bottom bytes per pair (0..2).
- param_outsl  in  2  byte count for the base-level value (1..2).
- param_m0  in  RP_D_SIZE  modulus M[i] for the level.
- param_m0inv  in  RP_INV_SIZE  floor(2^RP_INV_SIZE / m0).
- param_ro_offset  in  RP_DEPTH-1  write offset in the work buffer.

Behaviour:
- Reset state: done=0, cd_wr_en=0, cd_wr_addr=0, cd_wr_data=0, rp_rd_addr=0, state_*=0, FSM=IDLE.
- Parameter table mapping:
  - Load-stage parameters are indexed by state_l: outoffset, outs1, outsl, state_ct, ri_offset, ri_len.
  - Execute-stage parameters are indexed by state_e: m0, m0inv, small_r2, small_r3, r_max.
  - Store-stage parameters are indexed by state_s: ro_offset, ro_max.
  - All three stage indices change together at level boundaries; levels never overlap.
- FSM: IDLE -> BASE -> PAIRS (repeats per level) -> FIN -> IDLE.
- IDLE:
  - start=1 clears done, sets state_* = state_max, and enters BASE.
  - start while busy or while start is held high after acceptance is ignored.
- BASE level (small_r3=1):
  - v = little-endian value of outsl bytes at outoffset.
  - Store v mod m0 at internal work index 0.
  - Decrement the level and enter PAIRS.
- PAIRS, for j = 0..r_max:
  - r = (R2[j] << 8*outs1) | bottom, where bottom is the outs1 bytes at outoffset + j*outs1, little-endian.
  - R2[j] comes from the previous level's buffer at ri_offset + j.
  - R[2j] = r mod m0.
  - R[2j+1] = floor(r/m0) mod m0 for j < r_max; for j = r_max it is floor(r/m0) truncated to RP_D_SIZE, not reduced.
  - If small_r2=1, R[ro_max] = R2[r_max+1], copied unchanged.
  - Division uses m0inv for a quotient estimate plus at most 2 correction subtractions; the result must be exact for r < 2^(RP_D_SIZE+16).
  - Two internal ping-pong buffers of 2^RP_DEPTH x RP_D_SIZE hold the working values; the buffer roles swap every level.
  - Levels above 0 write only the internal buffer.
  - Level 0 writes cd_wr_* instead, one entry per cycle with cd_wr_en high, at addresses 0..ro_max in ascending order.
- FIN: one cycle after the last cd write, set done=1, state_*=0 and return to IDLE. done stays high and state_*=0 so external readers see level-0 ro_max.
- Throughput: at most 6 cycles per output coefficient plus 8 cycles per level.
- rst_n low mid-operation aborts immediately to the reset state; any partial cd contents are don't-care.

Test Plan:
- Basic pair: M=[3,3], table state_max=1 (L1: small_r3, outsl=1, m0=9, outoffset=0; L0: outs1=0, m0=3, r_max=0, ro_max=1), S=[7] -> cd=[1,2], done=1.
- Bottom bytes: M=[4591,4591] (L1: outoffset=2, outsl=2, m0=322; L0: outoffset=0, outs1=2, m0=4591), S=[34,12,05,00]h -> cd=[1788,72].
- Odd pass-through: M=[3,3,3], state_max=2, S=[26] -> level1 R2=[8,2] -> cd=[2,2,2] (cd[2] comes from the small_r2 copy).
- Out-of-range base: M=[3,3], S=[200] -> base value 2 -> cd=[2,0].
- Start held 6 cycles: exactly one decode runs; a second start pulse while busy is ignored; done stays high afterwards with state_*=0.
- rst_n pulsed low mid-decode -> done=0 and cd_wr_en=0 immediately; a new start then gives the correct cd values.
